// File: rtl/dbg_text_overlay_pkg.sv
// Shared constants, character codes, mix modes and the 5x7 glyph table
// for the debug text overlay.
package dbg_text_overlay_pkg;

  localparam int CELL_W  = 6;
  localparam int CELL_H  = 8;
  localparam int GLYPH_W = 5;
  localparam int GLYPH_H = 7;

  localparam logic [4:0] CH_SPACE = 5'h10;
  localparam logic [4:0] CH_G     = 5'h11;
  localparam logic [4:0] CH_H     = 5'h12;
  localparam logic [4:0] CH_I     = 5'h13;
  localparam logic [4:0] CH_K     = 5'h14;
  localparam logic [4:0] CH_L     = 5'h15;
  localparam logic [4:0] CH_M     = 5'h16;
  localparam logic [4:0] CH_N     = 5'h17;
  localparam logic [4:0] CH_O     = 5'h18;
  localparam logic [4:0] CH_P     = 5'h19;
  localparam logic [4:0] CH_R     = 5'h1A;
  localparam logic [4:0] CH_S     = 5'h1B;
  localparam logic [4:0] CH_T     = 5'h1C;
  localparam logic [4:0] CH_U     = 5'h1D;
  localparam logic [4:0] CH_X     = 5'h1E;
  localparam logic [4:0] CH_COLON = 5'h1F;

  typedef enum logic [1:0] {
    MIX_OR      = 2'd0,
    MIX_REPLACE = 2'd1,
    MIX_DIM     = 2'd2
  } mix_mode_e;

  // Seven 5-bit rows, top row in the MSBs, leftmost pixel is bit 4 of a row.
  function automatic logic [34:0] glyph_bits(input logic [4:0] code);
    logic [34:0] g;
    case (code)
      5'h00:    g = {5'h0E, 5'h11, 5'h13, 5'h15, 5'h19, 5'h11, 5'h0E};
      5'h01:    g = {5'h04, 5'h0C, 5'h04, 5'h04, 5'h04, 5'h04, 5'h0E};
      5'h02:    g = {5'h0E, 5'h11, 5'h01, 5'h02, 5'h04, 5'h08, 5'h1F};
      5'h03:    g = {5'h1F, 5'h02, 5'h04, 5'h02, 5'h01, 5'h11, 5'h0E};
      5'h04:    g = {5'h02, 5'h06, 5'h0A, 5'h12, 5'h1F, 5'h02, 5'h02};
      5'h05:    g = {5'h1F, 5'h10, 5'h1E, 5'h01, 5'h01, 5'h11, 5'h0E};
      5'h06:    g = {5'h06, 5'h08, 5'h10, 5'h1E, 5'h11, 5'h11, 5'h0E};
      5'h07:    g = {5'h1F, 5'h01, 5'h02, 5'h04, 5'h08, 5'h08, 5'h08};
      5'h08:    g = {5'h0E, 5'h11, 5'h11, 5'h0E, 5'h11, 5'h11, 5'h0E};
      5'h09:    g = {5'h0E, 5'h11, 5'h11, 5'h0F, 5'h01, 5'h02, 5'h0C};
      5'h0A:    g = {5'h0E, 5'h11, 5'h11, 5'h1F, 5'h11, 5'h11, 5'h11};
      5'h0B:    g = {5'h1E, 5'h11, 5'h11, 5'h1E, 5'h11, 5'h11, 5'h1E};
      5'h0C:    g = {5'h0E, 5'h11, 5'h10, 5'h10, 5'h10, 5'h11, 5'h0E};
      5'h0D:    g = {5'h1C, 5'h12, 5'h11, 5'h11, 5'h11, 5'h12, 5'h1C};
      5'h0E:    g = {5'h1F, 5'h10, 5'h10, 5'h1E, 5'h10, 5'h10, 5'h1F};
      5'h0F:    g = {5'h1F, 5'h10, 5'h10, 5'h1E, 5'h10, 5'h10, 5'h10};
      CH_G:     g = {5'h0E, 5'h11, 5'h10, 5'h17, 5'h11, 5'h11, 5'h0F};
      CH_H:     g = {5'h11, 5'h11, 5'h11, 5'h1F, 5'h11, 5'h11, 5'h11};
      CH_I:     g = {5'h0E, 5'h04, 5'h04, 5'h04, 5'h04, 5'h04, 5'h0E};
      CH_K:     g = {5'h11, 5'h12, 5'h14, 5'h18, 5'h14, 5'h12, 5'h11};
      CH_L:     g = {5'h10, 5'h10, 5'h10, 5'h10, 5'h10, 5'h10, 5'h1F};
      CH_M:     g = {5'h11, 5'h1B, 5'h15, 5'h15, 5'h11, 5'h11, 5'h11};
      CH_N:     g = {5'h11, 5'h11, 5'h19, 5'h15, 5'h13, 5'h11, 5'h11};
      CH_O:     g = {5'h0E, 5'h11, 5'h11, 5'h11, 5'h11, 5'h11, 5'h0E};
      CH_P:     g = {5'h1E, 5'h11, 5'h11, 5'h1E, 5'h10, 5'h10, 5'h10};
      CH_R:     g = {5'h1E, 5'h11, 5'h11, 5'h1E, 5'h14, 5'h12, 5'h11};
      CH_S:     g = {5'h0F, 5'h10, 5'h10, 5'h0E, 5'h01, 5'h01, 5'h1E};
      CH_T:     g = {5'h1F, 5'h04, 5'h04, 5'h04, 5'h04, 5'h04, 5'h04};
      CH_U:     g = {5'h11, 5'h11, 5'h11, 5'h11, 5'h11, 5'h11, 5'h0E};
      CH_X:     g = {5'h11, 5'h11, 5'h0A, 5'h04, 5'h0A, 5'h11, 5'h11};
      CH_COLON: g = {5'h00, 5'h0C, 5'h0C, 5'h00, 5'h0C, 5'h0C, 5'h00};
      default:  g = '0;
    endcase
    return g;
  endfunction

  // Row 7 is the inter-line gap and is always background.
  function automatic logic [4:0] glyph_row(input logic [4:0] code, input logic [2:0] row);
    logic [34:0] g;
    logic [4:0]  r;
    g = glyph_bits(code);
    case (row)
      3'd0:    r = g[34:30];
      3'd1:    r = g[29:25];
      3'd2:    r = g[24:20];
      3'd3:    r = g[19:15];
      3'd4:    r = g[14:10];
      3'd5:    r = g[9:5];
      3'd6:    r = g[4:0];
      default: r = 5'd0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/dbg_text_overlay_glyph_rom.sv
// Registered glyph row lookup: one ce_pix of latency from code/row to bits.
module dbg_glyph_rom
  import dbg_text_overlay_pkg::*;
(
  input  logic       clk_sys,
  input  logic       reset,
  input  logic       ce_pix,
  input  logic [4:0] code,
  input  logic [2:0] row,
  output logic [4:0] bits
);

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      bits <= 5'd0;
    end else if (ce_pix) begin
      bits <= glyph_row(code, row);
    end
  end

endmodule

// File: rtl/dbg_text_overlay.sv
// Debug text overlay: NUM_LINES x CHARS glyph box mixed onto the RGB stream
// through a 3-stage ce_pix pipeline, with text snapshotted at vblank rise.
module dbg_text_overlay
  import dbg_text_overlay_pkg::*;
#(
  parameter int NUM_LINES = 2,
  parameter int CHARS     = 32,
  parameter int SCALE     = 1,
  parameter int X0        = 16,
  parameter int Y0        = 16,
  parameter int MODE      = 0
) (
  input  logic                         clk_sys,
  input  logic                         reset,
  input  logic                         ce_pix,
  input  logic [8:0]                   hcount,
  input  logic [8:0]                   vcount,
  input  logic [7:0]                   i_r,
  input  logic [7:0]                   i_g,
  input  logic [7:0]                   i_b,
  input  logic                         i_hs,
  input  logic                         i_vs,
  input  logic                         i_hblank,
  input  logic                         i_vblank,
  input  logic                         ena,
  input  logic [NUM_LINES*CHARS*5-1:0] lines,
  input  logic [NUM_LINES*3-1:0]       line_rgb,
  output logic [7:0]                   o_r,
  output logic [7:0]                   o_g,
  output logic [7:0]                   o_b,
  output logic                         o_hs,
  output logic                         o_vs,
  output logic                         o_hblank,
  output logic                         o_vblank,
  output logic                         active
);

  localparam int CW = $clog2(CHARS + 1);
  localparam int RW = $clog2(NUM_LINES + 1);
  localparam logic [CW-1:0] CHR_END  = CW'(CHARS);
  localparam logic [RW-1:0] LINE_END = RW'(NUM_LINES);
  localparam logic          SUB_MAX  = (SCALE == 2);
  localparam mix_mode_e     MIX      = mix_mode_e'(MODE);

  logic [NUM_LINES*CHARS*5-1:0] snap_lines;
  logic [NUM_LINES*3-1:0]       snap_rgb;
  logic                         snap_ena;
  logic                         vb_q;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      snap_lines <= {(NUM_LINES*CHARS){CH_SPACE}};
      snap_rgb   <= '0;
      snap_ena   <= 1'b0;
      vb_q       <= 1'b0;
    end else begin
      vb_q <= i_vblank;
      if (i_vblank && !vb_q) begin
        snap_lines <= lines;
        snap_rgb   <= line_rgb;
        snap_ena   <= ena;
      end
    end
  end

  // Registered counters describe the current pixel except on the zeroing
  // pixel, where the combinational override forces position 0.
  logic          h_sub_q, h_sub_c, h_sub_n;
  logic [2:0]    h_col_q, h_col_c, h_col_n;
  logic [CW-1:0] h_chr_q, h_chr_c, h_chr_n;
  logic          v_sub_q, v_sub_c, v_sub_a;
  logic [2:0]    v_row_q, v_row_c, v_row_a;
  logic [RW-1:0] v_lin_q, v_lin_c, v_lin_a;

  always_comb begin
    h_sub_c = h_sub_q;
    h_col_c = h_col_q;
    h_chr_c = h_chr_q;
    if (hcount == 9'(X0)) begin
      h_sub_c = 1'b0;
      h_col_c = 3'd0;
      h_chr_c = '0;
    end
    h_sub_n = h_sub_c;
    h_col_n = h_col_c;
    h_chr_n = h_chr_c;
    if (h_chr_c != CHR_END) begin
      if (h_sub_c != SUB_MAX) begin
        h_sub_n = ~h_sub_c;
      end else begin
        h_sub_n = 1'b0;
        if (h_col_c != 3'd5) begin
          h_col_n = h_col_c + 3'd1;
        end else begin
          h_col_n = 3'd0;
          h_chr_n = h_chr_c + CW'(1);
        end
      end
    end
  end

  always_comb begin
    v_sub_a = v_sub_q;
    v_row_a = v_row_q;
    v_lin_a = v_lin_q;
    if (v_lin_q != LINE_END) begin
      if (v_sub_q != SUB_MAX) begin
        v_sub_a = ~v_sub_q;
      end else begin
        v_sub_a = 1'b0;
        v_row_a = v_row_q + 3'd1;
        if (v_row_q == 3'd7) v_lin_a = v_lin_q + RW'(1);
      end
    end
    v_sub_c = v_sub_q;
    v_row_c = v_row_q;
    v_lin_c = v_lin_q;
    if (hcount == 9'd0) begin
      if (vcount == 9'(Y0)) begin
        v_sub_c = 1'b0;
        v_row_c = 3'd0;
        v_lin_c = '0;
      end else begin
        v_sub_c = v_sub_a;
        v_row_c = v_row_a;
        v_lin_c = v_lin_a;
      end
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      h_sub_q <= 1'b0;
      h_col_q <= 3'd0;
      h_chr_q <= '0;
      v_sub_q <= 1'b0;
      v_row_q <= 3'd0;
      v_lin_q <= '0;
    end else if (ce_pix) begin
      h_sub_q <= h_sub_n;
      h_col_q <= h_col_n;
      h_chr_q <= h_chr_n;
      if (hcount == 9'd0) begin
        v_sub_q <= v_sub_c;
        v_row_q <= v_row_c;
        v_lin_q <= v_lin_c;
      end
    end
  end

  logic       in_box;
  logic [4:0] cur_code;
  logic [2:0] cur_rgb;

  always_comb begin
    in_box   = (h_chr_c != CHR_END) && (v_lin_c != LINE_END);
    cur_code = CH_SPACE;
    cur_rgb  = 3'd0;
    for (int r = 0; r < NUM_LINES; r++) begin
      if (v_lin_c == RW'(r)) begin
        cur_rgb = snap_rgb[(NUM_LINES-1-r)*3 +: 3];
        for (int c = 0; c < CHARS; c++) begin
          if (h_chr_c == CW'(c)) cur_code = snap_lines[((NUM_LINES-1-r)*CHARS + (CHARS-1-c))*5 +: 5];
        end
      end
    end
  end

  // Sync/blank travel packed as {hs, vs, hblank, vblank}.
  logic       s1_act, s2_act;
  logic [4:0] s1_code;
  logic [2:0] s1_row;
  logic [2:0] s1_col, s2_col;
  logic [2:0] s1_rgb, s2_rgb;
  logic [7:0] s1_r, s1_g, s1_b, s2_r, s2_g, s2_b;
  logic [3:0] s1_sync, s2_sync;
  logic [4:0] rom_bits;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      s1_act <= 1'b0; s1_code <= 5'd0; s1_row <= 3'd0; s1_col <= 3'd0; s1_rgb <= 3'd0;
      s1_r <= 8'd0; s1_g <= 8'd0; s1_b <= 8'd0; s1_sync <= 4'd0;
      s2_act <= 1'b0; s2_col <= 3'd0; s2_rgb <= 3'd0;
      s2_r <= 8'd0; s2_g <= 8'd0; s2_b <= 8'd0; s2_sync <= 4'd0;
    end else if (ce_pix) begin
      s1_act  <= in_box && snap_ena;
      s1_code <= cur_code;
      s1_row  <= v_row_c;
      s1_col  <= h_col_c;
      s1_rgb  <= cur_rgb;
      s1_r    <= i_r;
      s1_g    <= i_g;
      s1_b    <= i_b;
      s1_sync <= {i_hs, i_vs, i_hblank, i_vblank};
      s2_act  <= s1_act;
      s2_col  <= s1_col;
      s2_rgb  <= s1_rgb;
      s2_r    <= s1_r;
      s2_g    <= s1_g;
      s2_b    <= s1_b;
      s2_sync <= s1_sync;
    end
  end

  dbg_glyph_rom u_rom (
    .clk_sys (clk_sys),
    .reset   (reset),
    .ce_pix  (ce_pix),
    .code    (s1_code),
    .row     (s1_row),
    .bits    (rom_bits)
  );

  function automatic logic [7:0] mix(input logic [7:0] v, input logic fg, input logic on);
    logic [7:0] f;
    logic [7:0] res;
    f = {8{fg}};
    case (MIX)
      MIX_OR:      res = on ? (v | f) : v;
      MIX_REPLACE: res = on ? f : v;
      default:     res = on ? f : {2'b00, v[7:2]};
    endcase
    return res;
  endfunction

  logic       pix_on;
  logic       draw;
  logic [7:0] m_r, m_g, m_b;

  always_comb begin
    pix_on = (s2_col < 3'd5) ? rom_bits[3'd4 - s2_col] : 1'b0;
    draw   = s2_act && !s2_sync[1] && !s2_sync[0];
    m_r    = s2_r;
    m_g    = s2_g;
    m_b    = s2_b;
    if (draw) begin
      m_r = mix(s2_r, s2_rgb[2], pix_on);
      m_g = mix(s2_g, s2_rgb[1], pix_on);
      m_b = mix(s2_b, s2_rgb[0], pix_on);
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      o_r <= 8'd0; o_g <= 8'd0; o_b <= 8'd0;
      o_hs <= 1'b0; o_vs <= 1'b0; o_hblank <= 1'b0; o_vblank <= 1'b0;
      active <= 1'b0;
    end else if (ce_pix) begin
      o_r      <= m_r;
      o_g      <= m_g;
      o_b      <= m_b;
      {o_hs, o_vs, o_hblank, o_vblank} <= s2_sync;
      active   <= s2_act;
    end
  end

endmodule

// File: tb/tb_dbg_text_overlay.sv
// Randomized bench for dbg_text_overlay: three configurations share one raster
// and are compared pixel by pixel against a geometric reference model.
module tb_dbg_text_overlay;

  localparam int H_TOTAL = 72;
  localparam int V_TOTAL = 60;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, ce_pix, ena;
  logic [8:0]  hcount, vcount;
  logic [7:0]  i_r, i_g, i_b;
  logic        i_hs, i_vs, i_hblank, i_vblank;
  logic [79:0] lines8;
  logic [39:0] lines4;
  logic [5:0]  line_rgb;

  logic [7:0] o_r[3], o_g[3], o_b[3];
  logic       o_hs[3], o_vs[3], o_hblank[3], o_vblank[3], active[3];

  dbg_text_overlay #(.NUM_LINES(2), .CHARS(8), .SCALE(1), .X0(16), .Y0(16), .MODE(0)) dut0 (
    .clk_sys(clk), .reset(reset), .ce_pix(ce_pix), .hcount(hcount), .vcount(vcount),
    .i_r(i_r), .i_g(i_g), .i_b(i_b), .i_hs(i_hs), .i_vs(i_vs), .i_hblank(i_hblank), .i_vblank(i_vblank),
    .ena(ena), .lines(lines8), .line_rgb(line_rgb),
    .o_r(o_r[0]), .o_g(o_g[0]), .o_b(o_b[0]), .o_hs(o_hs[0]), .o_vs(o_vs[0]),
    .o_hblank(o_hblank[0]), .o_vblank(o_vblank[0]), .active(active[0]));

  dbg_text_overlay #(.NUM_LINES(2), .CHARS(4), .SCALE(2), .X0(16), .Y0(16), .MODE(1)) dut1 (
    .clk_sys(clk), .reset(reset), .ce_pix(ce_pix), .hcount(hcount), .vcount(vcount),
    .i_r(i_r), .i_g(i_g), .i_b(i_b), .i_hs(i_hs), .i_vs(i_vs), .i_hblank(i_hblank), .i_vblank(i_vblank),
    .ena(ena), .lines(lines4), .line_rgb(line_rgb),
    .o_r(o_r[1]), .o_g(o_g[1]), .o_b(o_b[1]), .o_hs(o_hs[1]), .o_vs(o_vs[1]),
    .o_hblank(o_hblank[1]), .o_vblank(o_vblank[1]), .active(active[1]));

  dbg_text_overlay #(.NUM_LINES(2), .CHARS(8), .SCALE(1), .X0(0), .Y0(0), .MODE(2)) dut2 (
    .clk_sys(clk), .reset(reset), .ce_pix(ce_pix), .hcount(hcount), .vcount(vcount),
    .i_r(i_r), .i_g(i_g), .i_b(i_b), .i_hs(i_hs), .i_vs(i_vs), .i_hblank(i_hblank), .i_vblank(i_vblank),
    .ena(ena), .lines(lines8), .line_rgb(line_rgb),
    .o_r(o_r[2]), .o_g(o_g[2]), .o_b(o_b[2]), .o_hs(o_hs[2]), .o_vs(o_vs[2]),
    .o_hblank(o_hblank[2]), .o_vblank(o_vblank[2]), .active(active[2]));

  // Bench-side text and the model's frame snapshot of it.
  logic [4:0] txt[2][8];
  logic [2:0] rgb_in[2];
  logic [4:0] m_txt[2][8];
  logic [2:0] m_rgb[2];
  logic       m_ena, prev_vb;
  logic [4:0] code_set[8] = '{5'h01, 5'h08, 5'h0A, 5'h10, 5'h11, 5'h1F, 5'h0F, 5'h1C};

  logic [86:0] exp_q[$];
  logic [86:0] last_exp;
  int          n_checks = 0;
  int          n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (h=%0d v=%0d t=%0t)", tag, got, exp, hcount, vcount, $time);
    end
  endtask

  function automatic logic [4:0] ref_glyph(input logic [4:0] code, input int row);
    logic [34:0] g;
    case (code)
      5'h01:   g = {5'h04, 5'h0C, 5'h04, 5'h04, 5'h04, 5'h04, 5'h0E};
      5'h08:   g = {5'h0E, 5'h11, 5'h11, 5'h0E, 5'h11, 5'h11, 5'h0E};
      5'h0A:   g = {5'h0E, 5'h11, 5'h11, 5'h1F, 5'h11, 5'h11, 5'h11};
      5'h0F:   g = {5'h1F, 5'h10, 5'h10, 5'h1E, 5'h10, 5'h10, 5'h10};
      5'h11:   g = {5'h0E, 5'h11, 5'h10, 5'h17, 5'h11, 5'h11, 5'h0F};
      5'h1C:   g = {5'h1F, 5'h04, 5'h04, 5'h04, 5'h04, 5'h04, 5'h04};
      5'h1F:   g = {5'h00, 5'h0C, 5'h0C, 5'h00, 5'h0C, 5'h0C, 5'h00};
      default: g = '0;
    endcase
    if (row > 6) return 5'd0;
    return g[(6-row)*5 +: 5];
  endfunction

  function automatic logic [7:0] ref_mix(input logic [7:0] v, input logic fg, input logic on, input int md);
    logic [7:0] f;
    f = fg ? 8'hFF : 8'h00;
    if (md == 0) return on ? (v | f) : v;
    if (on) return f;
    return (md == 1) ? v : (v / 4);
  endfunction

  // Expected {active, hs, vs, hblank, vblank, r, g, b} for the current input pixel.
  function automatic logic [28:0] ref_pix(input int d);
    int x0, y0, nch, sc, md, dx, dy, chr, col, row, gr;
    logic inb, on;
    logic [4:0] gb;
    logic [2:0] fg;
    logic [7:0] r, g, b;
    case (d)
      0:       begin x0 = 16; y0 = 16; nch = 8; sc = 1; md = 0; end
      1:       begin x0 = 16; y0 = 16; nch = 4; sc = 2; md = 1; end
      default: begin x0 = 0;  y0 = 0;  nch = 8; sc = 1; md = 2; end
    endcase
    dx  = int'(hcount) - x0;
    dy  = int'(vcount) - y0;
    inb = (dx >= 0) && (dx < nch*6*sc) && (dy >= 0) && (dy < 2*8*sc);
    r = i_r; g = i_g; b = i_b;
    if (inb && m_ena && !i_hblank && !i_vblank) begin
      chr = dx / (6*sc);
      col = (dx / sc) % 6;
      row = dy / (8*sc);
      gr  = (dy / sc) % 8;
      fg  = m_rgb[row];
      gb  = ref_glyph(m_txt[row][chr], gr);
      on  = (col < 5) ? gb[4-col] : 1'b0;
      r = ref_mix(i_r, fg[2], on, md);
      g = ref_mix(i_g, fg[1], on, md);
      b = ref_mix(i_b, fg[0], on, md);
    end
    return {inb && m_ena, i_hs, i_vs, i_hblank, i_vblank, r, g, b};
  endfunction

  function automatic logic [28:0] got_pix(input int d);
    return {active[d], o_hs[d], o_vs[d], o_hblank[d], o_vblank[d], o_r[d], o_g[d], o_b[d]};
  endfunction

  task automatic pack_inputs();
    for (int r = 0; r < 2; r++) begin
      line_rgb[(1-r)*3 +: 3] = rgb_in[r];
      for (int c = 0; c < 8; c++) lines8[((1-r)*8 + (7-c))*5 +: 5] = txt[r][c];
      for (int c = 0; c < 4; c++) lines4[((1-r)*4 + (3-c))*5 +: 5] = txt[r][c];
    end
  endtask

  task automatic new_text(input logic force_ena);
    for (int r = 0; r < 2; r++) begin
      rgb_in[r] = 3'($urandom_range(1, 7));
      for (int c = 0; c < 8; c++) txt[r][c] = code_set[$urandom_range(0, 7)];
    end
    txt[0][0] = 5'h01;
    rgb_in[0] = 3'b111;
    ena = force_ena || ($urandom_range(0, 7) != 0);
    pack_inputs();
  endtask

  task automatic tick(input logic ce_v, input logic rst_v);
    logic [28:0] e;
    @(negedge clk);
    ce_pix = ce_v;
    reset  = rst_v;
    if (rst_v) begin
      m_ena   = 1'b0;
      prev_vb = 1'b0;
      for (int r = 0; r < 2; r++) begin
        m_rgb[r] = 3'd0;
        for (int c = 0; c < 8; c++) m_txt[r][c] = 5'h10;
      end
      exp_q.delete();
      exp_q.push_back('0);
      exp_q.push_back('0);
      last_exp = '0;
    end else begin
      if (ce_v) exp_q.push_back({ref_pix(2), ref_pix(1), ref_pix(0)});
      if (i_vblank && !prev_vb) begin
        m_txt = txt;
        m_rgb = rgb_in;
        m_ena = ena;
      end
      prev_vb = i_vblank;
    end
    @(posedge clk);
    #1;
    if (!rst_v && ce_v) last_exp = exp_q.pop_front();
    for (int d = 0; d < 3; d++) begin
      e = last_exp[d*29 +: 29];
      if (rst_v)     check($sformatf("reset_dut%0d", d), {3'b0, got_pix(d)}, 32'd0);
      else if (ce_v) check($sformatf("pix_dut%0d", d),   {3'b0, got_pix(d)}, {3'b0, e});
      else           check($sformatf("hold_dut%0d", d),  {3'b0, got_pix(d)}, {3'b0, e});
    end
  endtask

  initial begin
    int nclk;
    logic do_rst;
    reset = 1'b1; ce_pix = 1'b0;
    hcount = 9'd0; vcount = 9'd0;
    i_r = 8'd0; i_g = 8'd0; i_b = 8'd0;
    i_hs = 1'b0; i_vs = 1'b0; i_hblank = 1'b0; i_vblank = 1'b0;
    lines8 = '0; lines4 = '0; line_rgb = '0;
    new_text(1'b1);
    tick(1'b0, 1'b1);
    tick(1'b0, 1'b1);
    for (int f = 0; f < 6; f++) begin
      for (int v = 0; v < V_TOTAL; v++) begin
        for (int h = 0; h < H_TOTAL; h++) begin
          hcount   = 9'(h);
          vcount   = 9'(v);
          i_hblank = (h >= 66);
          i_hs     = (h >= 67) && (h <= 69);
          i_vblank = (v >= 56);
          i_vs     = (v >= 57) && (v <= 58);
          if (f == 1)      begin i_r = 8'h00; i_g = 8'h00; i_b = 8'h00; end
          else if (f == 3) begin i_r = 8'h80; i_g = 8'h80; i_b = 8'h80; end
          else begin
            i_r = 8'($urandom); i_g = 8'($urandom); i_b = 8'($urandom);
          end
          do_rst = 1'b0;
          if (v == 20 && h == 30) begin
            do_rst = (f == 4);
            if (f != 0) new_text(1'b0);
          end
          nclk = (f == 2) ? $urandom_range(1, 3) : ((f >= 4) ? 4 : 1);
          for (int k = 0; k < nclk; k++) tick(k == nclk - 1, do_rst && (k == 1));
        end
      end
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/dbg_text_overlay.md
Name: dbg_text_overlay

Overview:
- Parametrised successor to the fixed two-line debug overlay on the CoCo2 top level.
- Renders NUM_LINES rows of CHARS 5-bit-coded characters onto the core's RGB stream at a programmable origin, integer scale and mix mode.
- Line contents are snapshotted once per frame, so the overlay never tears.
- Sits between the po8 video outputs and VGA_R/G/B/HS/VS/DE. The pixel pipeline delays video, sync and blank together.

Parameters:
- NUM_LINES, 2, number of text rows (1..8).
- CHARS, 32, characters per row (1..64).
- SCALE, 1, glyph pixel replication in both axes (1 or 2).
- X0, 16, hcount of the first overlay pixel.
- Y0, 16, vcount of the first overlay line.
- MODE, 0, mix mode: 0 = OR fg into video; 1 = replace with fg where glyph bit set; 2 = as 1, with the cell background dimmed to video>>2.

Ports:
- clk_sys  in  1  system clock.
- reset  in  1  synchronous, active-high.
- ce_pix  in  1  pixel enable; all pipeline stages advance only when ce_pix=1.
- hcount  in  9  current pixel column.
- vcount  in  9  current line.
- i_r, i_g, i_b  in  8 each  video in.
- i_hs, i_vs, i_hblank, i_vblank  in  1 each  sync/blank in.
- ena  in  1  overlay enable.
- lines  in  NUM_LINES*CHARS*5  packed text. Row 0 is the MSB block; within a row, char 0 (leftmost) is the MSBs.
- line_rgb  in  NUM_LINES*3  per-row fg colour {R,G,B}; each bit expands to 8'hFF or 8'h00.
- o_r, o_g, o_b  out  8 each  mixed video.
- o_hs, o_vs, o_hblank, o_vblank  out  1 each  sync/blank delayed to match o_r/g/b.
- active  out  1  high when the current output pixel lies inside the overlay box and the snapshot ena=1.

Behaviour:
- Reset: all outputs 0. Snapshot text = all 0x10 (space). Snapshot ena = 0. All counters = 0.
- Snapshot: on the clk_sys cycle where i_vblank rises (0→1, edge detected in clk_sys), latch lines, line_rgb and ena. Display uses only the snapshot.
- Cell geometry: 6*SCALE wide x 8*SCALE high. The glyph is 5x7 at the cell's top-left; column 5 and row 7 are always background.
- Horizontal counters (sub-pixel 0..SCALE-1, glyph column 0..5, char index 0..CHARS-1):
  - zeroed on the ce_pix where hcount==X0;
  - advance on each subsequent ce_pix;
  - char index saturates at CHARS, meaning outside.
- Vertical counters (sub-line, glyph row 0..7, row index):
  - zeroed on the ce_pix where hcount==0 && vcount==Y0;
  - advance on each subsequent ce_pix where hcount==0;
  - row index saturates at NUM_LINES.
- Division and multiplication by non-constants are forbidden.
- Pipeline: 3 ce_pix-qualified stages. Output pixel n corresponds to input pixel n-3. Sync and blank are delayed identically.
  - S1: register in-box flag, char code (mux from snapshot), glyph row, glyph column, row colour.
  - S2: glyph ROM lookup; register the 5-bit row bits.
  - S3: select the bit (column 5 → 0) and mix.
- Mixing rules:
  - Outside the box, snapshot ena=0, or either blank asserted: o = delayed input, unmodified.
  - MODE 0: o = in | fg.
  - MODE 1: o = bit ? fg : in.
  - MODE 2: o = bit ? fg : {2'b00, in[7:2]}.
- Character codes:
  - 0x00-0x0F → hex digits 0-F.
  - 0x10 → space.
  - 0x11-0x1F → G H I K L M N O P R S T U X ':'.
- Between ce_pix pulses all registers hold.
- Reset mid-frame: snapshot clears at once, so no overlay until the next vblank rise. The pipeline flushes to 0 and refills within 3 ce_pix.
- hcount ≥ X0 + CHARS*6*SCALE or vcount beyond the box → outside. A box clipped by the raster edge is simply truncated; no wrap.

Decomposition:
- Package dbg_text_overlay_pkg:
  - CELL_W=6, CELL_H=8, GLYPH_W=5, GLYPH_H=7;
  - character-code localparams (CH_SPACE=5'h10, etc.);
  - mix-mode enum;
  - the 32x7x5 glyph table as a constant function.
- Sub-module dbg_glyph_rom: 5-bit code + 3-bit row in, registered 5-bit row bits out, one ce_pix latency. This is stage S2.

Test Plan:
- Reset, then ena=1 but no vblank edge → o_r/g/b equal input delayed 3 ce_pix and active=0 for a full frame.
- Row 0 = "1" (5'h01) at char 0, line_rgb[0]=3'b111, MODE 0, X0=Y0=16, input black; vblank pulse → next frame o_r=8'hFF exactly at the glyph-'1' pixel locations (hcount 16..20, vcount 16..22, plus 3-pixel latency) and 0 elsewhere.
- Same stimulus with SCALE=2 → each set pixel covers 2x2. Box width = CHARS*12 pixels. char CHARS-1 ends at hcount X0+CHARS*12-1.
- MODE 2, input gray 8'h80, code 0x10 everywhere → box pixels = 8'h20, outside = 8'h80.
- Change lines mid-frame → output unchanged until after the next i_vblank rise.
- ce_pix every 4th clk_sys plus assert reset at vcount 20 → outputs 0 on the next clk_sys. No overlay until the following vblank rise. Sync delay stays 3 ce_pix.
